// File: rtl/irq_pkg.sv
// Shared types and helpers for the N-source interrupt controller.
// Holds the claim FSM state encoding and the vector address helper.
package irq_pkg;

  localparam int MAX_SRC = 32;
  localparam int MAX_VEC = 64;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE
  } state_e;

  function automatic logic [MAX_VEC-1:0] vec_of(
    input logic [MAX_VEC-1:0] base,
    input logic [MAX_VEC-1:0] stride,
    input logic [MAX_VEC-1:0] id
  );
    return base + stride * id;
  endfunction

endpackage

// File: rtl/irq_ctrl_n_prio_enc.sv
// Lowest-index-first one finder over the request vector.
// Purely combinational; index 0 has the highest priority.
module irq_ctrl_n_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_n.sv
// N-source interrupt controller: mask, edge/level mode, pending latch,
// vector table and a claim/ack/release handshake toward the CPU.
module irq_ctrl_n
  import irq_pkg::*;
#(
  parameter int               NUM_SRC    = 8,
  parameter int               VEC_W      = 32,
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(32'h0000_0100),
  parameter int               VEC_STRIDE = 4,
  parameter int               ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] mask,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic               ack,
  output logic               INT,
  output logic [VEC_W-1:0]   INT_INSTR,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_SRC-1:0] pending
);

  state_e             state_q, state_d;
  logic               int_q, int_d;
  logic [VEC_W-1:0]   instr_q, instr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] clr;
  logic               ack_clr;
  logic               enc_vld;
  logic [ID_W-1:0]    enc_id;

  assign rise = src & ~prev_q;
  assign req  = mask & ((pend_q & edge_mode) | (src & ~edge_mode));

  irq_ctrl_n_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_enc (
    .req_i   (req),
    .valid_o (enc_vld),
    .id_o    (enc_id)
  );

  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    instr_d = instr_q;
    id_d    = id_q;
    ack_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enc_vld) begin
          id_d    = enc_id;
          instr_d = VEC_W'(vec_of(MAX_VEC'(VEC_BASE),
                                  MAX_VEC'(VEC_STRIDE),
                                  MAX_VEC'(enc_id)));
          int_d   = 1'b1;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (ack) begin
          ack_clr = 1'b1;
          int_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge in the ack cycle must survive, so set is applied last.
  assign clr    = ack_clr ? (NUM_SRC'(1) << id_q) : '0;
  assign pend_d = (pend_q & ~(clr & edge_mode)) | (rise & edge_mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      int_q   <= 1'b0;
      instr_q <= '0;
      id_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      instr_q <= instr_d;
      id_q    <= id_d;
      prev_q  <= src;
      pend_q  <= pend_d;
    end
  end

  assign INT       = int_q;
  assign INT_INSTR = instr_q;
  assign int_id    = id_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Self-checking bench for irq_ctrl_n (8-source and 32-source instances).
// Expected claims are queued at stimulus time and popped on each claim.
module tb_irq_ctrl_n;

  typedef struct {
    logic [4:0]  id;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src, mask, edge_mode, pending;
  logic        ack, INT;
  logic [31:0] INT_INSTR;
  logic [2:0]  int_id;

  logic [31:0] src32, mask32, edge32, pend32;
  logic        ack32, INT32;
  logic [31:0] instr32;
  logic [4:0]  id32;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  irq_ctrl_n dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .mask      (mask),
    .edge_mode (edge_mode),
    .ack       (ack),
    .INT       (INT),
    .INT_INSTR (INT_INSTR),
    .int_id    (int_id),
    .pending   (pending)
  );

  irq_ctrl_n #(.NUM_SRC(32)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .src       (src32),
    .mask      (mask32),
    .edge_mode (edge32),
    .ack       (ack32),
    .INT       (INT32),
    .INT_INSTR (instr32),
    .int_id    (id32),
    .pending   (pend32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src = '0; mask = 8'hFF; edge_mode = 8'hFF; ack = 1'b0;
    src32 = '0; mask32 = '1; edge32 = '1; ack32 = 1'b0;
    tick();
    tick();
    total++;
    if (INT !== 1'b0 || pending !== 8'h00 || INT_INSTR !== 32'h0 || int_id !== 3'd0) begin
      bad++;
      $display("FAIL reset8 INT=%b pend=%h instr=%h id=%0d want 0/00/0/0",
               INT, pending, INT_INSTR, int_id);
    end
    total++;
    if (INT32 !== 1'b0 || pend32 !== 32'h0 || instr32 !== 32'h0 || id32 !== 5'd0) begin
      bad++;
      $display("FAIL reset32 INT=%b pend=%h instr=%h id=%0d want 0/0/0/0",
               INT32, pend32, instr32, id32);
    end
    rst = 1'b0;
    tick();
    total++;
    if (INT !== 1'b0) begin
      bad++; $display("FAIL reset_idle INT=%b want 0", INT);
    end
  endtask

  task automatic test_single_edge();
    exp_t e;
    src = 8'h01;
    sb.push_back('{5'd0, 32'h100});
    tick();
    src = 8'h00;
    total++;
    if (pending !== 8'h01 || INT !== 1'b0) begin
      bad++; $display("FAIL t1_pend pend=%h INT=%b want 01/0", pending, INT);
    end
    tick();
    e = sb.pop_front();
    total++;
    if (INT !== 1'b1 || int_id !== e.id[2:0] || INT_INSTR !== e.instr) begin
      bad++;
      $display("FAIL t1_claim INT=%b id=%0d instr=%h want 1/%0d/%h",
               INT, int_id, INT_INSTR, e.id, e.instr);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++;
    if (INT !== 1'b0 || pending !== 8'h00) begin
      bad++; $display("FAIL t1_ack INT=%b pend=%h want 0/00", INT, pending);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    exp_t e;
    src = 8'h28;
    sb.push_back('{5'd3, 32'h10C});
    sb.push_back('{5'd5, 32'h114});
    tick();
    src = 8'h00;
    tick();
    e = sb.pop_front();
    total++;
    if (INT !== 1'b1 || int_id !== e.id[2:0] || INT_INSTR !== e.instr) begin
      bad++;
      $display("FAIL t2_first INT=%b id=%0d instr=%h want 1/%0d/%h",
               INT, int_id, INT_INSTR, e.id, e.instr);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++;
    if (INT !== 1'b0 || pending !== 8'h20) begin
      bad++; $display("FAIL t2_ack INT=%b pend=%h want 0/20", INT, pending);
    end
    tick();
    total++;
    if (INT !== 1'b0) begin
      bad++; $display("FAIL t2_gap INT=%b want 0", INT);
    end
    tick();
    e = sb.pop_front();
    total++;
    if (INT !== 1'b1 || int_id !== e.id[2:0] || INT_INSTR !== e.instr) begin
      bad++;
      $display("FAIL t2_second INT=%b id=%0d instr=%h want 1/%0d/%h",
               INT, int_id, INT_INSTR, e.id, e.instr);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  task automatic test_mask();
    exp_t e;
    mask = 8'hFB;
    src = 8'h04;
    sb.push_back('{5'd2, 32'h108});
    tick();
    src = 8'h00;
    tick();
    tick();
    total++;
    if (pending !== 8'h04 || INT !== 1'b0) begin
      bad++; $display("FAIL t3_masked pend=%h INT=%b want 04/0", pending, INT);
    end
    mask = 8'hFF;
    tick();
    e = sb.pop_front();
    total++;
    if (INT !== 1'b1 || int_id !== e.id[2:0] || INT_INSTR !== e.instr) begin
      bad++;
      $display("FAIL t3_unmask INT=%b id=%0d instr=%h want 1/%0d/%h",
               INT, int_id, INT_INSTR, e.id, e.instr);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    total++;
    if (pending !== 8'h00) begin
      bad++; $display("FAIL t3_clear pend=%h want 00", pending);
    end
  endtask

  task automatic test_level_ack_held();
    exp_t e;
    int   claims;
    edge_mode = 8'hFD;
    src = 8'h02;
    sb.push_back('{5'd1, 32'h104});
    tick();
    e = sb.pop_front();
    total++;
    if (INT !== 1'b1 || int_id !== e.id[2:0] || INT_INSTR !== e.instr || pending !== 8'h00) begin
      bad++;
      $display("FAIL t4_claim INT=%b id=%0d instr=%h pend=%h want 1/%0d/%h/00",
               INT, int_id, INT_INSTR, pending, e.id, e.instr);
    end
    ack = 1'b1;
    claims = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (INT === 1'b1) claims++;
    end
    total++;
    if (claims !== 0) begin
      bad++; $display("FAIL t4_held claims=%0d want 0", claims);
    end
    ack = 1'b0;
    sb.push_back('{5'd1, 32'h104});
    tick();
    tick();
    e = sb.pop_front();
    total++;
    if (INT !== 1'b1 || int_id !== e.id[2:0] || INT_INSTR !== e.instr) begin
      bad++;
      $display("FAIL t4_reclaim INT=%b id=%0d instr=%h want 1/%0d/%h",
               INT, int_id, INT_INSTR, e.id, e.instr);
    end
    ack = 1'b1;
    tick();
    src = 8'h00;
    ack = 1'b0;
    claims = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (INT === 1'b1) claims++;
    end
    total++;
    if (claims !== 0) begin
      bad++; $display("FAIL t4_quiet claims=%0d want 0", claims);
    end
    edge_mode = 8'hFF;
  endtask

  task automatic test_no_preempt();
    exp_t e;
    src = 8'h10;
    sb.push_back('{5'd4, 32'h110});
    tick();
    src = 8'h00;
    tick();
    e = sb.pop_front();
    total++;
    if (INT !== 1'b1 || int_id !== e.id[2:0] || INT_INSTR !== e.instr) begin
      bad++;
      $display("FAIL t5_claim4 INT=%b id=%0d instr=%h want 1/%0d/%h",
               INT, int_id, INT_INSTR, e.id, e.instr);
    end
    src = 8'h01;
    sb.push_back('{5'd0, 32'h100});
    tick();
    src = 8'h00;
    total++;
    if (INT !== 1'b1 || int_id !== 3'd4 || INT_INSTR !== 32'h110 || pending !== 8'h11) begin
      bad++;
      $display("FAIL t5_hold INT=%b id=%0d instr=%h pend=%h want 1/4/110/11",
               INT, int_id, INT_INSTR, pending);
    end
    src = 8'h10;
    ack = 1'b1;
    sb.push_back('{5'd4, 32'h110});
    tick();
    src = 8'h00;
    ack = 1'b0;
    total++;
    if (INT !== 1'b0 || pending !== 8'h11) begin
      bad++; $display("FAIL t5_setwins INT=%b pend=%h want 0/11", INT, pending);
    end
    tick();
    tick();
    e = sb.pop_front();
    total++;
    if (INT !== 1'b1 || int_id !== e.id[2:0] || INT_INSTR !== e.instr) begin
      bad++;
      $display("FAIL t5_claim0 INT=%b id=%0d instr=%h want 1/%0d/%h",
               INT, int_id, INT_INSTR, e.id, e.instr);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    tick();
    e = sb.pop_front();
    total++;
    if (INT !== 1'b1 || int_id !== e.id[2:0] || INT_INSTR !== e.instr) begin
      bad++;
      $display("FAIL t5_reclaim4 INT=%b id=%0d instr=%h want 1/%0d/%h",
               INT, int_id, INT_INSTR, e.id, e.instr);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    total++;
    if (pending !== 8'h00 || INT !== 1'b0) begin
      bad++; $display("FAIL t5_done pend=%h INT=%b want 00/0", pending, INT);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    src = 8'h02;
    sb.push_back('{5'd1, 32'h104});
    tick();
    src = 8'h00;
    tick();
    e = sb.pop_front();
    total++;
    if (INT !== 1'b1 || int_id !== e.id[2:0] || INT_INSTR !== e.instr) begin
      bad++;
      $display("FAIL t6_claim INT=%b id=%0d instr=%h want 1/%0d/%h",
               INT, int_id, INT_INSTR, e.id, e.instr);
    end
    src = 8'h08;
    tick();
    src = 8'h00;
    total++;
    if (pending !== 8'h0A) begin
      bad++; $display("FAIL t6_pend pend=%h want 0A", pending);
    end
    rst = 1'b1;
    tick();
    total++;
    if (INT !== 1'b0 || pending !== 8'h00 || INT_INSTR !== 32'h0 || int_id !== 3'd0) begin
      bad++;
      $display("FAIL t6_abort INT=%b pend=%h instr=%h id=%0d want 0/00/0/0",
               INT, pending, INT_INSTR, int_id);
    end
    rst = 1'b0;
    tick();
    tick();
    total++;
    if (INT !== 1'b0) begin
      bad++; $display("FAIL t6_lost INT=%b want 0", INT);
    end
  endtask

  task automatic test_wide();
    exp_t e;
    src32 = 32'h8000_0000;
    sb.push_back('{5'd31, 32'h17C});
    tick();
    src32 = '0;
    tick();
    e = sb.pop_front();
    total++;
    if (INT32 !== 1'b1 || id32 !== e.id || instr32 !== e.instr) begin
      bad++;
      $display("FAIL t6_wide INT=%b id=%0d instr=%h want 1/%0d/%h",
               INT32, id32, instr32, e.id, e.instr);
    end
    ack32 = 1'b1;
    tick();
    ack32 = 1'b0;
    tick();
    total++;
    if (INT32 !== 1'b0 || pend32 !== 32'h0 || instr32 !== 32'h17C) begin
      bad++;
      $display("FAIL t6_wide_ack INT=%b pend=%h instr=%h want 0/0/17C",
               INT32, pend32, instr32);
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_same_cycle();
    test_mask();
    test_level_ack_held();
    test_no_preempt();
    test_reset_abort();
    test_wide();
    total++;
    if (sb.size() !== 0) begin
      bad++; $display("FAIL sb_empty left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
